axi_dma_mem_slave: RTL and testbench

AXI_DMA_MEM_SLAVE -- requirements
Module: axi_dma_mem_slave

---
 rtl/axi_dma_mem_slave.sv | 249 ++++++++++++++++++++++++
 tb/tb_axi_dma_mem_slave.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/axi_dma_mem_slave.sv
// AXI4 memory endpoint for the DMA master: independent read/write channel FSMs
// sharing one dual-port word array with per-byte write strobes.
module axi_dma_mem_slave #(
  parameter int  MEM_WORDS = 1024,
  parameter int  RD_STALL  = 0,
  parameter type axi_tid_t = logic [3:0]
) (
  input  logic        clk,
  input  logic        rst,
  // AW
  input  axi_tid_t    awid,
  input  logic [31:0] awaddr,
  input  logic [7:0]  awlen,
  input  logic [2:0]  awsize,
  input  logic [1:0]  awburst,
  input  logic        awlock,
  input  logic [3:0]  awcache,
  input  logic [2:0]  awprot,
  input  logic [3:0]  awqos,
  input  logic [3:0]  awregion,
  input  logic        awuser,
  input  logic        awvalid,
  output logic        awready,
  // W
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  input  logic        wlast,
  input  logic        wuser,
  input  logic        wvalid,
  output logic        wready,
  // B
  output axi_tid_t    bid,
  output logic [1:0]  bresp,
  output logic        buser,
  output logic        bvalid,
  input  logic        bready,
  // AR
  input  axi_tid_t    arid,
  input  logic [31:0] araddr,
  input  logic [7:0]  arlen,
  input  logic [2:0]  arsize,
  input  logic [1:0]  arburst,
  input  logic        arlock,
  input  logic [3:0]  arcache,
  input  logic [2:0]  arprot,
  input  logic [3:0]  arqos,
  input  logic [3:0]  arregion,
  input  logic        aruser,
  input  logic        arvalid,
  output logic        arready,
  // R
  output axi_tid_t    rid,
  output logic [31:0] rdata,
  output logic [1:0]  rresp,
  output logic        rlast,
  output logic        ruser,
  output logic        rvalid,
  input  logic        rready
);
  localparam int          AW         = $clog2(MEM_WORDS);
  localparam logic [15:0] STALL_INIT = (RD_STALL > 0) ? 16'(RD_STALL - 1) : 16'd0;
  localparam logic [1:0]  OKAY       = 2'b00;
  localparam logic [1:0]  SLVERR     = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  typedef enum logic [1:0] {R_IDLE, R_STALL, R_DATA} r_state_t;

  logic [31:0] mem [MEM_WORDS];

  logic unused;
  assign unused = ^{awlock, awcache, awprot, awqos, awregion, awuser, wuser,
                    arlock, arcache, arprot, arqos, arregion, aruser};
  assign buser = 1'b0;
  assign ruser = 1'b0;

  // FIXED holds the address; INCR steps by the beat size, wrapping mod 2^32
  function automatic logic [31:0] next_addr(input logic [31:0] a, input logic [2:0] size,
                                            input logic [1:0] burst);
    return (burst == 2'b01) ? a + (32'd1 << size) : a;
  endfunction

  // ---------------- write path ----------------
  w_state_t    w_state, w_next;
  axi_tid_t    w_id;
  logic [31:0] w_addr;
  logic [7:0]  w_len, w_cnt;
  logic [2:0]  w_size;
  logic [1:0]  w_burst;
  logic        w_err;
  logic        aw_hs, w_hs, w_last_beat, w_beat_bad, w_fault;

  assign awready     = (w_state == W_IDLE);
  assign wready      = (w_state == W_DATA);
  assign bvalid      = (w_state == W_RESP);
  assign bid         = w_id;
  assign aw_hs       = awvalid && awready;
  assign w_hs        = wvalid && wready;
  assign w_last_beat = (w_cnt == w_len);
  assign w_beat_bad  = (w_size > 3'd2) || w_burst[1] || (w_addr[31:AW+2] != '0);
  assign w_fault     = w_beat_bad || (wlast != w_last_beat);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) w_state <= W_IDLE;
    else     w_state <= w_next;
  end

  // Burst length comes from awlen alone; wlast is only cross-checked
  always_comb begin
    w_next = w_state;
    case (w_state)
      W_IDLE:  if (awvalid)              w_next = W_DATA;
      W_DATA:  if (wvalid && w_last_beat) w_next = W_RESP;
      W_RESP:  if (bready)               w_next = W_IDLE;
      default:                           w_next = W_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_id    <= '0;
      w_addr  <= '0;
      w_len   <= '0;
      w_cnt   <= '0;
      w_size  <= '0;
      w_burst <= '0;
      w_err   <= 1'b0;
      bresp   <= OKAY;
    end else begin
      if (aw_hs) begin
        w_id    <= awid;
        w_addr  <= awaddr;
        w_len   <= awlen;
        w_size  <= awsize;
        w_burst <= awburst;
        w_cnt   <= '0;
        w_err   <= 1'b0;
      end
      if (w_hs) begin
        w_addr <= next_addr(w_addr, w_size, w_burst);
        w_cnt  <= w_cnt + 8'd1;
        w_err  <= w_err || w_fault;
        if (w_last_beat) bresp <= (w_err || w_fault) ? SLVERR : OKAY;
      end
    end
  end

  // Bad beats are still consumed, they just never reach the array
  always_ff @(posedge clk) begin
    if (w_hs && !w_beat_bad)
      for (int b = 0; b < 4; b++)
        if (wstrb[b]) mem[w_addr[AW+1:2]][8*b +: 8] <= wdata[8*b +: 8];
  end

  // ---------------- read path ----------------
  r_state_t    r_state, r_next;
  axi_tid_t    r_id;
  logic [31:0] r_addr, ld_addr;
  logic [7:0]  r_len, r_cnt, ld_cnt, cur_len;
  logic [2:0]  r_size, cur_size;
  logic [1:0]  r_burst, cur_burst;
  logic [15:0] stall_cnt;
  logic        ar_hs, ld, ld_err;

  assign arready   = (r_state == R_IDLE);
  assign rvalid    = (r_state == R_DATA);
  assign rid       = r_id;
  assign ar_hs     = arvalid && arready;
  assign cur_len   = ar_hs ? arlen   : r_len;
  assign cur_size  = ar_hs ? arsize  : r_size;
  assign cur_burst = ar_hs ? arburst : r_burst;
  assign ld_err    = (cur_size > 3'd2) || cur_burst[1] || (ld_addr[31:AW+2] != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= R_IDLE;
    else     r_state <= r_next;
  end

  // ld registers the next beat into the R output regs; rdata stays stable while stalled
  always_comb begin
    r_next  = r_state;
    ld      = 1'b0;
    ld_addr = r_addr;
    ld_cnt  = r_cnt;
    case (r_state)
      R_IDLE: if (arvalid) begin
        if (RD_STALL == 0) begin
          r_next  = R_DATA;
          ld      = 1'b1;
          ld_addr = araddr;
          ld_cnt  = '0;
        end else begin
          r_next = R_STALL;
        end
      end
      R_STALL: if (stall_cnt == '0) begin
        r_next = R_DATA;
        ld     = 1'b1;
        ld_cnt = '0;
      end
      R_DATA: if (rready) begin
        if (rlast) begin
          r_next = R_IDLE;
        end else begin
          ld      = 1'b1;
          ld_addr = next_addr(r_addr, r_size, r_burst);
          ld_cnt  = r_cnt + 8'd1;
        end
      end
      default: r_next = R_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_id      <= '0;
      r_addr    <= '0;
      r_len     <= '0;
      r_cnt     <= '0;
      r_size    <= '0;
      r_burst   <= '0;
      stall_cnt <= '0;
      rdata     <= '0;
      rresp     <= OKAY;
      rlast     <= 1'b0;
    end else begin
      if (ar_hs) begin
        r_id      <= arid;
        r_addr    <= araddr;
        r_len     <= arlen;
        r_size    <= arsize;
        r_burst   <= arburst;
        r_cnt     <= '0;
        stall_cnt <= STALL_INIT;
      end else if (r_state == R_STALL && stall_cnt != '0) begin
        stall_cnt <= stall_cnt - 16'd1;
      end
      if (ld) begin
        r_addr <= ld_addr;
        r_cnt  <= ld_cnt;
        rdata  <= ld_err ? '0 : mem[ld_addr[AW+1:2]];
        rresp  <= ld_err ? SLVERR : OKAY;
        rlast  <= (ld_cnt == cur_len);
      end else if (rvalid && rready && rlast) begin
        rlast <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_axi_dma_mem_slave.sv
// Directed bench for axi_dma_mem_slave: bursts, strobes, range/illegal errors,
// rready backpressure and mid-burst reset.
module tb_axi_dma_mem_slave;
  localparam int MEM_WORDS = 1024;

  logic        clk = 1'b0, rst;
  logic [3:0]  awid, bid, arid, rid;
  logic [31:0] awaddr, wdata, araddr, rdata;
  logic [7:0]  awlen, arlen;
  logic [2:0]  awsize, arsize, awprot, arprot;
  logic [1:0]  awburst, arburst, bresp, rresp;
  logic [3:0]  awcache, awqos, awregion, arcache, arqos, arregion, wstrb;
  logic        awlock, awuser, awvalid, awready, wlast, wuser, wvalid, wready;
  logic        buser, bvalid, bready, arlock, aruser, arvalid, arready;
  logic        rlast, ruser, rvalid, rready;

  axi_dma_mem_slave #(.MEM_WORDS(MEM_WORDS), .RD_STALL(0)) dut (
    .clk(clk), .rst(rst),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awlock(awlock), .awcache(awcache), .awprot(awprot), .awqos(awqos),
    .awregion(awregion), .awuser(awuser), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wuser(wuser), .wvalid(wvalid),
    .wready(wready),
    .bid(bid), .bresp(bresp), .buser(buser), .bvalid(bvalid), .bready(bready),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arlock(arlock), .arcache(arcache), .arprot(arprot), .arqos(arqos),
    .arregion(arregion), .aruser(aruser), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .ruser(ruser),
    .rvalid(rvalid), .rready(rready)
  );

  always #5 clk = ~clk;

  int          n_cmp = 0, n_err = 0;
  logic [31:0] wr_data [16];
  logic [31:0] rd_data [16];
  logic [1:0]  rd_resp [16];
  logic        rd_last [16];
  int          rd_n;
  logic [1:0]  b_resp;
  logic [3:0]  b_id;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // wlast is driven on beat index wl_at (== len for a well-formed burst)
  task automatic axi_write(input logic [31:0] addr, input int len, input logic [2:0] size,
                           input logic [1:0] burst, input logic [3:0] strb, input int wl_at,
                           input logic [3:0] id);
    int t;
    @(negedge clk);
    awid = id; awaddr = addr; awlen = 8'(len); awsize = size; awburst = burst; awvalid = 1'b1;
    t = 0;
    while (!awready && t < 50) begin @(negedge clk); t++; end
    if (t >= 50) chk("aw_timeout", 32'(t), 0);
    @(negedge clk);
    awvalid = 1'b0;
    for (int i = 0; i <= len; i++) begin
      wdata = wr_data[i]; wstrb = strb; wlast = (i == wl_at); wvalid = 1'b1;
      t = 0;
      while (!wready && t < 50) begin @(negedge clk); t++; end
      if (t >= 50) chk("w_timeout", 32'(t), 0);
      @(negedge clk);
    end
    wvalid = 1'b0; wlast = 1'b0; bready = 1'b1;
    t = 0;
    while (!bvalid && t < 50) begin @(negedge clk); t++; end
    if (t >= 50) chk("b_timeout", 32'(t), 0);
    b_resp = bresp; b_id = bid;
    @(negedge clk);
    bready = 1'b0;
  endtask

  // tog=1 drives rready 1,0,1,0... and checks outputs hold across each stall
  task automatic axi_read(input logic [31:0] addr, input int len, input logic [2:0] size,
                          input logic [1:0] burst, input logic [3:0] id, input bit tog);
    int t;
    logic held, hl;
    logic [31:0] hd;
    @(negedge clk);
    arid = id; araddr = addr; arlen = 8'(len); arsize = size; arburst = burst; arvalid = 1'b1;
    t = 0;
    while (!arready && t < 50) begin @(negedge clk); t++; end
    if (t >= 50) chk("ar_timeout", 32'(t), 0);
    @(negedge clk);
    arvalid = 1'b0;
    chk("r_first_latency", 32'(rvalid), 1);
    rd_n = 0; held = 1'b0; hl = 1'b0; hd = '0; t = 0;
    while (rd_n <= len && t < 200) begin
      rready = tog ? (t % 2 == 0) : 1'b1;
      if (held) begin
        chk("r_hold_valid", 32'(rvalid), 1);
        chk("r_hold_data", rdata, hd);
        chk("r_hold_last", 32'(rlast), 32'(hl));
      end
      held = 1'b0;
      if (rvalid && rready) begin
        rd_data[rd_n] = rdata; rd_resp[rd_n] = rresp; rd_last[rd_n] = rlast;
        chk("r_id", 32'(rid), 32'(id));
        rd_n++;
      end else if (rvalid) begin
        held = 1'b1; hd = rdata; hl = rlast;
      end
      @(negedge clk);
      t++;
    end
    rready = 1'b0;
    if (t >= 200) chk("r_timeout", 32'(t), 0);
    chk("r_arready_after", 32'(arready), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    awid = '0; awaddr = '0; awlen = '0; awsize = '0; awburst = '0; awlock = 1'b0;
    awcache = '0; awprot = '0; awqos = '0; awregion = '0; awuser = 1'b0; awvalid = 1'b0;
    wdata = '0; wstrb = '0; wlast = 1'b0; wuser = 1'b0; wvalid = 1'b0; bready = 1'b0;
    arid = '0; araddr = '0; arlen = '0; arsize = '0; arburst = '0; arlock = 1'b0;
    arcache = '0; arprot = '0; arqos = '0; arregion = '0; aruser = 1'b0; arvalid = 1'b0;
    rready = 1'b0;
    repeat (2) @(negedge clk);

    // reset state
    chk("rst_awready", 32'(awready), 1);
    chk("rst_arready", 32'(arready), 1);
    chk("rst_wready", 32'(wready), 0);
    chk("rst_bvalid", 32'(bvalid), 0);
    chk("rst_rvalid", 32'(rvalid), 0);
    chk("rst_rlast", 32'(rlast), 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_resp", {28'd0, bresp, rresp}, 0);
    chk("rst_ids", {24'd0, bid, rid}, 0);
    chk("rst_user", {30'd0, buser, ruser}, 0);
    rst = 1'b0;

    // 4-beat INCR write then read back
    for (int i = 0; i < 4; i++) wr_data[i] = 32'hA5A5_0000 + i;
    axi_write(32'h10, 3, 3'd2, 2'b01, 4'hF, 3, 4'd5);
    chk("incr_bresp", 32'(b_resp), 0);
    chk("incr_bid", 32'(b_id), 5);
    axi_read(32'h10, 3, 3'd2, 2'b01, 4'd6, 1'b0);
    chk("incr_nbeats", 32'(rd_n), 4);
    for (int i = 0; i < 4; i++) begin
      chk("incr_rdata", rd_data[i], 32'hA5A5_0000 + i);
      chk("incr_rresp", 32'(rd_resp[i]), 0);
      chk("incr_rlast", 32'(rd_last[i]), 32'(i == 3));
    end

    // byte strobes merge into an existing word
    wr_data[0] = 32'hAABB_CCDD;
    axi_write(32'h100, 0, 3'd2, 2'b01, 4'hF, 0, 4'd1);
    wr_data[0] = 32'h1122_3344;
    axi_write(32'h100, 0, 3'd2, 2'b01, 4'h3, 0, 4'd1);
    chk("strb_bresp", 32'(b_resp), 0);
    axi_read(32'h100, 0, 3'd2, 2'b01, 4'd2, 1'b0);
    chk("strb_rdata", rd_data[0], 32'hAABB_3344);
    chk("strb_rlast", 32'(rd_last[0]), 1);

    // 8-beat read with rready toggling
    for (int i = 0; i < 8; i++) wr_data[i] = 32'h0BAD_0000 + i;
    axi_write(32'h200, 7, 3'd2, 2'b01, 4'hF, 7, 4'd3);
    axi_read(32'h200, 7, 3'd2, 2'b01, 4'd4, 1'b1);
    chk("tog_nbeats", 32'(rd_n), 8);
    for (int i = 0; i < 8; i++) begin
      chk("tog_rdata", rd_data[i], 32'h0BAD_0000 + i);
      chk("tog_rlast", 32'(rd_last[i]), 32'(i == 7));
    end

    // burst running off the top of memory
    wr_data[0] = 32'hCAFE_F00D; wr_data[1] = 32'h1234_5678;
    axi_write(4 * MEM_WORDS - 4, 1, 3'd2, 2'b01, 4'hF, 1, 4'd7);
    chk("oor_bresp", 32'(b_resp), 2);
    axi_read(4 * MEM_WORDS - 4, 1, 3'd2, 2'b01, 4'd7, 1'b0);
    chk("oor_rdata0", rd_data[0], 32'hCAFE_F00D);
    chk("oor_rresp0", 32'(rd_resp[0]), 0);
    chk("oor_rdata1", rd_data[1], 0);
    chk("oor_rresp1", 32'(rd_resp[1]), 2);
    chk("oor_rlast1", 32'(rd_last[1]), 1);

    // early wlast: all beats still consumed, SLVERR
    for (int i = 0; i < 4; i++) wr_data[i] = 32'h5555_0000 + i;
    axi_write(32'h300, 3, 3'd2, 2'b01, 4'hF, 2, 4'd8);
    chk("wlast_bresp", 32'(b_resp), 2);
    chk("wlast_bid", 32'(b_id), 8);

    // FIXED burst leaves only the last beat
    for (int i = 0; i < 4; i++) wr_data[i] = 32'h0000_F1D0 + i;
    axi_write(32'h400, 3, 3'd2, 2'b00, 4'hF, 3, 4'd9);
    chk("fixed_bresp", 32'(b_resp), 0);
    axi_read(32'h400, 0, 3'd2, 2'b01, 4'd9, 1'b0);
    chk("fixed_rdata", rd_data[0], 32'h0000_F1D3);

    // illegal size on write, WRAP on read
    wr_data[0] = 32'hDEAD_BEEF;
    axi_write(32'h500, 0, 3'd3, 2'b01, 4'hF, 0, 4'd2);
    chk("size_bresp", 32'(b_resp), 2);
    axi_read(32'h10, 0, 3'd2, 2'b10, 4'd2, 1'b0);
    chk("wrap_rresp", 32'(rd_resp[0]), 2);
    chk("wrap_rdata", rd_data[0], 0);

    // reset while beat 2 of a read is on the bus
    @(negedge clk);
    arid = 4'd11; araddr = 32'h10; arlen = 8'd3; arsize = 3'd2; arburst = 2'b01; arvalid = 1'b1;
    @(negedge clk);
    arvalid = 1'b0; rready = 1'b1;
    repeat (2) @(negedge clk);
    chk("mid_rvalid_pre", 32'(rvalid), 1);
    chk("mid_rdata_pre", rdata, 32'hA5A5_0002);
    rst = 1'b1;
    #1;
    chk("mid_rvalid_rst", 32'(rvalid), 0);
    chk("mid_arready_rst", 32'(arready), 1);
    chk("mid_rdata_rst", rdata, 0);
    @(negedge clk);
    rst = 1'b0; rready = 1'b0;
    axi_read(32'h10, 0, 3'd2, 2'b01, 4'd12, 1'b0);
    chk("post_rst_rdata", rd_data[0], 32'hA5A5_0000);
    chk("post_rst_rresp", 32'(rd_resp[0]), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
